// File: rtl/fc_layer.sv
// Dense layer after the 2x2 pooling stage: buffers one frame, then runs one MAC pass per neuron
// against an external synchronous weight/bias ROM. Define FC_RELU_EN to clamp negative results to zero.
module fc_layer #(
  parameter  int IN_LEN    = 196,
  parameter  int OUT_LEN   = 10,
  parameter  int DATA_SIZE = 16,
  parameter  int FRAC_BITS = 8,
  localparam int AW        = $clog2(OUT_LEN*IN_LEN+OUT_LEN),
  localparam int IW        = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_SIZE-1:0] input_data,
  input  logic                        input_valid,
  output logic                        weight_rd_en,
  output logic [AW-1:0]               weight_addr,
  input  logic signed [DATA_SIZE-1:0] weight_data,
  output logic signed [DATA_SIZE-1:0] out_data,
  output logic                        out_valid,
  output logic [IW-1:0]               out_index,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        overflow_err
);

  localparam int PW     = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int KW     = $clog2(IN_LEN+1);
  localparam int PROD_W = 2*DATA_SIZE;
  localparam int ACC_W  = PROD_W + KW;

  localparam logic signed [DATA_SIZE-1:0] OUT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [DATA_SIZE-1:0] OUT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {COLLECT, MAC, DRAIN, EMIT} state_e;

  function automatic logic signed [DATA_SIZE-1:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> FRAC_BITS;
    if (shifted > ACC_W'(OUT_MAX))      return OUT_MAX;
    else if (shifted < ACC_W'(OUT_MIN)) return OUT_MIN;
    else                                return shifted[DATA_SIZE-1:0];
  endfunction

  function automatic logic signed [DATA_SIZE-1:0] relu(input logic signed [DATA_SIZE-1:0] v);
`ifdef FC_RELU_EN
    return v[DATA_SIZE-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [KW-1:0]   k_q, k_d;
  logic            drn_q, drn_d;
  logic [IW-1:0]   nrn_q, nrn_d;
  logic            ovf_q, ovf_d;

  logic signed [DATA_SIZE-1:0] mem_q [IN_LEN];

  logic                        vld_p0_q, first_p0_q, bias_p0_q;
  logic signed [DATA_SIZE-1:0] x_p0_q;
  logic                        vld_p1_q, first_p1_q;
  logic signed [PROD_W-1:0]    prod_p1_q, prod_d;
  logic signed [ACC_W-1:0]     acc_p2_q;

  logic                        out_valid_q, frame_done_q;
  logic [IW-1:0]               out_index_q;
  logic signed [DATA_SIZE-1:0] out_data_q;

  logic k_is_bias, last_nrn;
  assign k_is_bias = (k_q == KW'(IN_LEN));
  assign last_nrn  = (nrn_q == IW'(OUT_LEN-1));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    k_d     = k_q;
    drn_d   = drn_q;
    nrn_d   = nrn_q;
    ovf_d   = ovf_q | (input_valid & (state_q != COLLECT));
    case (state_q)
      COLLECT: begin
        if (input_valid) begin
          wr_d = wr_q + 1'b1;
          if (wr_q == PW'(IN_LEN-1)) begin
            wr_d    = '0;
            k_d     = '0;
            nrn_d   = '0;
            state_d = MAC;
          end
        end
      end
      MAC: begin
        if (k_is_bias) begin
          drn_d   = 1'b0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q) state_d = EMIT;
        else       drn_d   = 1'b1;
      end
      EMIT: begin
        if (last_nrn) begin
          nrn_d   = '0;
          state_d = COLLECT;
        end else begin
          nrn_d   = nrn_q + 1'b1;
          k_d     = '0;
          state_d = MAC;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      wr_q         <= '0;
      k_q          <= '0;
      drn_q        <= 1'b0;
      nrn_q        <= '0;
      ovf_q        <= 1'b0;
      vld_p0_q     <= 1'b0;
      first_p0_q   <= 1'b0;
      bias_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      first_p1_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_index_q  <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      k_q          <= k_d;
      drn_q        <= drn_d;
      nrn_q        <= nrn_d;
      ovf_q        <= ovf_d;
      // p0: ROM word returns; matching buffer sample registered alongside
      vld_p0_q     <= (state_q == MAC);
      first_p0_q   <= (state_q == MAC) && (k_q == '0);
      bias_p0_q    <= (state_q == MAC) && k_is_bias;
      // p1: product (or aligned bias) registered
      vld_p1_q     <= vld_p0_q;
      first_p1_q   <= first_p0_q;
      // result stage: emit registers, zero between strobes
      out_valid_q  <= (state_q == EMIT);
      frame_done_q <= (state_q == EMIT) && last_nrn;
      out_index_q  <= (state_q == EMIT) ? nrn_q : '0;
      out_data_q   <= (state_q == EMIT) ? relu(saturate(acc_p2_q)) : '0;
    end
  end

  // Bias replaces the product term, pre-scaled to the accumulator's Q position
  always_comb begin
    prod_d = PROD_W'(x_p0_q) * PROD_W'(weight_data);
    if (bias_p0_q) prod_d = PROD_W'(weight_data) <<< FRAC_BITS;
  end

  always_ff @(posedge clk) begin
    if (input_valid && (state_q == COLLECT)) mem_q[wr_q] <= input_data;
    x_p0_q <= mem_q[k_q[PW-1:0]];
    if (vld_p0_q) prod_p1_q <= prod_d;
    // p2: accumulate, restarting on the first term of each neuron
    if (vld_p1_q) acc_p2_q <= first_p1_q ? ACC_W'(prod_p1_q) : acc_p2_q + ACC_W'(prod_p1_q);
  end

  assign busy         = (state_q != COLLECT);
  assign overflow_err = ovf_q;
  assign weight_rd_en = (state_q == MAC);
  assign weight_addr  = (state_q != MAC) ? '0 :
                        k_is_bias ? AW'(OUT_LEN*IN_LEN) + AW'(nrn_q)
                                  : AW'(nrn_q) * AW'(IN_LEN) + AW'(k_q);
  assign out_valid    = out_valid_q;
  assign frame_done   = frame_done_q;
  assign out_index    = out_index_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer (IN_LEN=4, OUT_LEN=2) with a registered ROM model and result scoreboard.
module tb_fc_layer;
  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 2;
  localparam int DS      = 16;
  localparam int FRAC    = 8;
  localparam int AW      = $clog2(OUT_LEN*IN_LEN+OUT_LEN);
  localparam int IW      = 1;
  localparam int LAT     = IN_LEN + 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DS-1:0] input_data = '0;
  logic                 input_valid = 1'b0;
  logic                 weight_rd_en;
  logic [AW-1:0]        weight_addr;
  logic signed [DS-1:0] weight_data = '0;
  logic signed [DS-1:0] out_data;
  logic                 out_valid;
  logic [IW-1:0]        out_index;
  logic                 frame_done;
  logic                 busy;
  logic                 overflow_err;

  fc_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_SIZE(DS), .FRAC_BITS(FRAC)) dut (
    .clk(clk), .rst(rst), .input_data(input_data), .input_valid(input_valid),
    .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .weight_data(weight_data),
    .out_data(out_data), .out_valid(out_valid), .out_index(out_index),
    .frame_done(frame_done), .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  logic signed [DS-1:0] rom [OUT_LEN*IN_LEN+OUT_LEN];
  logic signed [DS-1:0] in_vec [IN_LEN];

  always @(posedge clk) if (weight_rd_en) weight_data <= rom[weight_addr];

  typedef struct {
    logic signed [DS-1:0] data;
    int                   idx;
    bit                   done;
    int                   cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic set_rom_uniform(input int w0, input int b0, input int w1, input int b1);
    for (int i = 0; i < IN_LEN; i++) begin
      rom[i]        = DS'(w0);
      rom[IN_LEN+i] = DS'(w1);
    end
    rom[OUT_LEN*IN_LEN]   = DS'(b0);
    rom[OUT_LEN*IN_LEN+1] = DS'(b1);
  endtask

  task automatic set_inputs_uniform(input int x);
    for (int i = 0; i < IN_LEN; i++) in_vec[i] = DS'(x);
  endtask

  task automatic randomize_all();
    for (int i = 0; i < OUT_LEN*IN_LEN+OUT_LEN; i++) rom[i] = DS'(int'($urandom_range(0, 8000)) - 4000);
    for (int i = 0; i < IN_LEN; i++) in_vec[i] = DS'(int'($urandom_range(0, 8000)) - 4000);
  endtask

  function automatic logic signed [DS-1:0] model(input int o);
    longint acc = 0;
    for (int i = 0; i < IN_LEN; i++) acc += longint'(in_vec[i]) * longint'(rom[o*IN_LEN+i]);
    acc += longint'(rom[OUT_LEN*IN_LEN+o]) * 256;
    acc = acc >>> FRAC;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return DS'(acc);
  endfunction

  task automatic push_frame(input logic signed [DS-1:0] e0, input logic signed [DS-1:0] e1);
    sb.push_back('{e0, 0, 1'b0, LAT});
    sb.push_back('{e1, 1, 1'b1, 2*LAT});
  endtask

  task automatic push_model();
    push_frame(model(0), model(1));
  endtask

  task automatic drive_frame(input int start);
    for (int i = start; i < IN_LEN; i++) begin
      @(negedge clk);
      input_valid = 1'b1;
      input_data  = in_vec[i];
    end
    @(posedge clk);
    #1 input_valid = 1'b0;
  endtask

  // Cycle numbers count edges after the one capturing the last sample.
  task automatic wait_results(input int inj_cyc, input bit b2b, input logic signed [DS-1:0] next0);
    int   got = 0;
    exp_t e;
    for (int cyc = 1; cyc <= 5*LAT && got < OUT_LEN; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == inj_cyc) begin
        input_valid = 1'b1;
        input_data  = 16'sd1234;
      end else if (cyc == inj_cyc + 1) begin
        input_valid = 1'b0;
      end
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_frame: got %b want 1", busy); end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid at cycle %0d: data %0d", cyc, out_data);
        end else begin
          e = sb.pop_front();
          got++;
          checks += 3;
          if (out_data !== e.data) begin errors++; $display("FAIL out_data[%0d]: got %0d want %0d", e.idx, out_data, e.data); end
          if (int'(out_index) != e.idx) begin errors++; $display("FAIL out_index: got %0d want %0d", out_index, e.idx); end
          if (frame_done !== e.done) begin errors++; $display("FAIL frame_done[%0d]: got %b want %b", e.idx, frame_done, e.done); end
          if (cyc != e.cyc) begin errors++; $display("FAIL latency[%0d]: got %0d want %0d", e.idx, cyc, e.cyc); end
          if (b2b && e.done) begin
            input_valid = 1'b1;
            input_data  = next0;
          end
        end
      end else begin
        checks++;
        if (out_data !== '0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs at cycle %0d: data %0d done %b want 0 0", cyc, out_data, frame_done);
        end
      end
    end
    checks++;
    if (got != OUT_LEN) begin errors++; $display("FAIL result_timeout: got %0d results want %0d", got, OUT_LEN); end
  endtask

  task automatic check_idle_state(input string tag);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || weight_rd_en !== 1'b0 ||
        weight_addr !== '0 || frame_done !== 1'b0 || out_index !== '0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy %b vld %b data %0d rd %b addr %0d done %b idx %0d ovf %b want all 0",
               tag, busy, out_valid, out_data, weight_rd_en, weight_addr, frame_done, out_index, overflow_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_state("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_rom_uniform(256, 0, 128, 256);
    set_inputs_uniform(256);
    push_frame(16'sd1024, 16'sd768);
    drive_frame(0);
    wait_results(-5, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      randomize_all();
      push_model();
      drive_frame(0);
      wait_results(-5, 1'b0, '0);
    end
  endtask

  task automatic test_saturation();
    set_rom_uniform(32767, 32767, -32767, -32767);
    set_inputs_uniform(32767);
`ifdef FC_RELU_EN
    push_frame(16'sd32767, 16'sd0);
`else
    push_frame(16'sd32767, -16'sd32768);
`endif
    drive_frame(0);
    wait_results(-5, 1'b0, '0);
  endtask

  task automatic test_negative();
    set_rom_uniform(-128, 0, -128, 0);
    set_inputs_uniform(256);
`ifdef FC_RELU_EN
    push_frame(16'sd0, 16'sd0);
`else
    push_frame(-16'sd512, -16'sd512);
`endif
    drive_frame(0);
    wait_results(-5, 1'b0, '0);
  endtask

  task automatic test_overflow();
    randomize_all();
    push_model();
    drive_frame(0);
    wait_results(3, 1'b0, '0);
    checks++;
    if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", overflow_err); end
    randomize_all();
    push_model();
    drive_frame(0);
    wait_results(-5, 1'b0, '0);
    checks++;
    if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", overflow_err); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    set_rom_uniform(256, 0, 128, 256);
    set_inputs_uniform(256);
    drive_frame(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_state("reset_mid_state");
    for (int c = 0; c < 3*LAT; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_abort: got out_valid after reset want none"); end
    randomize_all();
    push_model();
    drive_frame(0);
    wait_results(-5, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic signed [DS-1:0] vec_b [IN_LEN];
    randomize_all();
    for (int i = 0; i < IN_LEN; i++) vec_b[i] = DS'(int'($urandom_range(0, 8000)) - 4000);
    push_model();
    drive_frame(0);
    for (int i = 0; i < IN_LEN; i++) in_vec[i] = vec_b[i];
    wait_results(-5, 1'b1, in_vec[0]);
    push_model();
    drive_frame(1);
    wait_results(-5, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_saturation();
    test_negative();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
